// File: rtl/spi_rpi_pkg.sv
// ============================================================================
// Module : spi_rpi_pkg
// Brief  : Shared constants, defaults and command decode for spi_slave_rpi_par
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi_rpi_pkg;

    localparam int c_CMD_ENABLE   = 0;
    localparam int c_CMD_READ     = 1;
    localparam int c_CMD_WRITE    = 2;

    localparam int c_DEF_DATA_W   = 1024;
    localparam int c_DEF_CMD_W    = 8;
    localparam int c_DEF_CPOL     = 0;
    localparam int c_DEF_CPHA     = 0;
    localparam int c_DEF_FILTER   = 5;

    typedef struct packed {
        logic write;
        logic read;
    } cmd_flags_t;

    // READ and WRITE only take effect when ENABLE is also set
    function automatic cmd_flags_t decode_cmd(input logic [2:0] c);
        cmd_flags_t f;
        f.read  = c[c_CMD_ENABLE] & c[c_CMD_READ];
        f.write = c[c_CMD_ENABLE] & c[c_CMD_WRITE];
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_filter.sv
// ============================================================================
// Module : spi_sync_filter
// Brief  : 2-FF synchroniser followed by a consecutive-sample glitch filter
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sync_filter #(
    parameter int   FILTER    = 5,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], din};
        end
    end

    generate
        if (FILTER == 0) begin : g_bypass
            assign dout = r_sync[1];
        end else begin : g_filter
            localparam int c_CW = $clog2(FILTER + 1);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(FILTER - 1);
            localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

            logic [c_CW-1:0] r_cnt;
            logic            r_out;

            // Output follows only after FILTER consecutive disagreeing samples
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= RESET_VAL;
                    r_cnt <= '0;
                end else if (r_sync[1] != r_out) begin
                    if (r_cnt == c_LAST) begin
                        r_out <= r_sync[1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign dout = r_out;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_slave_rpi_par.sv
// ============================================================================
// Module : spi_slave_rpi_par
// Brief  : SPI slave with command/status phase and wide parallel payload
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_slave_rpi_par
    import spi_rpi_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int CMD_W  = c_DEF_CMD_W,
    parameter int CPOL   = c_DEF_CPOL,
    parameter int CPHA   = c_DEF_CPHA,
    parameter int FILTER = c_DEF_FILTER
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SPI_CS,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    input  logic [DATA_W-1:0] DATA_TX,
    input  logic [CMD_W-1:0]  STATUS_TX,
    output logic [DATA_W-1:0] DATA_RX,
    output logic [CMD_W-1:0]  CMD,
    output logic              BUSY,
    output logic              RX_VALID,
    output logic              TX_LATCH,
    output logic              FRAME_ERR
);

    localparam int c_TOTAL = CMD_W + DATA_W;
    localparam int c_CNT_W = $clog2(c_TOTAL + 2);

    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST = c_CNT_W'(CMD_W - 1);
    localparam logic [c_CNT_W-1:0] c_CMD_CNT  = c_CNT_W'(CMD_W);
    localparam logic [c_CNT_W-1:0] c_TOT_CNT  = c_CNT_W'(c_TOTAL);
    localparam logic [c_CNT_W-1:0] c_SAT_CNT  = c_CNT_W'(c_TOTAL + 1);

    localparam logic c_SAMPLE_RISE = (CPOL == CPHA);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    logic w_cs, w_sclk, w_mosi;

    spi_sync_filter #(.FILTER(FILTER), .RESET_VAL(1'b1)) u_cs_filt (
        .clk(CLK), .rst(RESET), .din(SPI_CS), .dout(w_cs)
    );
    spi_sync_filter #(.FILTER(FILTER), .RESET_VAL(1'(CPOL))) u_sclk_filt (
        .clk(CLK), .rst(RESET), .din(SPI_CLK), .dout(w_sclk)
    );
    spi_sync_filter #(.FILTER(FILTER), .RESET_VAL(1'b0)) u_mosi_filt (
        .clk(CLK), .rst(RESET), .din(SPI_MOSI), .dout(w_mosi)
    );

    logic               r_cs_d, r_sclk_d;
    logic [0:0]         r_state, w_state_nxt;
    logic               w_busy, w_frame_start, w_frame_end;
    logic               w_sample, w_shift;
    logic [c_CNT_W-1:0] r_bit_cnt, r_out_cnt;
    logic               r_overrun, r_read_en, r_write_en;
    logic [CMD_W-2:0]   r_cmd_sr;
    logic [CMD_W-1:0]   w_cmd_new, r_status_sr;
    logic [DATA_W-1:0]  r_rx_sr, r_tx_sr;
    cmd_flags_t         w_flags;
    logic               r_miso, r_rx_valid, r_tx_latch, r_frame_err;

    wire w_cs_fall   =  r_cs_d   & ~w_cs;
    wire w_cs_rise   = ~r_cs_d   &  w_cs;
    wire w_sclk_rise = ~r_sclk_d &  w_sclk;
    wire w_sclk_fall =  r_sclk_d & ~w_sclk;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_cs_fall) w_state_nxt = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_cs_rise) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_frame_start = w_cs_fall;
            c_ST_ACTIVE: begin
                w_busy      = 1'b1;
                w_frame_end = w_cs_rise;
            end
            default:     w_busy = 1'b0;
        endcase
    end

    // SPI clock edges only matter inside a frame that is not ending this cycle
    assign w_sample  = w_busy & ~w_frame_end & (c_SAMPLE_RISE ? w_sclk_rise : w_sclk_fall);
    assign w_shift   = w_busy & ~w_frame_end & (c_SAMPLE_RISE ? w_sclk_fall : w_sclk_rise);
    assign w_cmd_new = {w_mosi, r_cmd_sr};
    assign w_flags   = decode_cmd(w_cmd_new[2:0]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'(CPOL);
            r_bit_cnt   <= '0;
            r_out_cnt   <= '0;
            r_overrun   <= 1'b0;
            r_read_en   <= 1'b0;
            r_write_en  <= 1'b0;
            r_cmd_sr    <= '0;
            r_status_sr <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_miso      <= 1'b0;
            DATA_RX     <= '0;
            CMD         <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_latch  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cs_d      <= w_cs;
            r_sclk_d    <= w_sclk;
            r_rx_valid  <= 1'b0;
            r_tx_latch  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_frame_start) begin
                r_bit_cnt  <= '0;
                r_overrun  <= 1'b0;
                r_read_en  <= 1'b0;
                r_write_en <= 1'b0;
                r_cmd_sr   <= '0;
                r_rx_sr    <= '0;
                r_tx_sr    <= '0;
                // With CPHA=0 the first status bit must be valid before the first clock edge
                if (CPHA == 0) begin
                    r_miso      <= STATUS_TX[0];
                    r_status_sr <= {1'b0, STATUS_TX[CMD_W-1:1]};
                    r_out_cnt   <= c_ONE;
                end else begin
                    r_miso      <= 1'b0;
                    r_status_sr <= STATUS_TX;
                    r_out_cnt   <= '0;
                end
            end else if (w_frame_end) begin
                r_miso <= 1'b0;
                if (r_write_en && (r_bit_cnt == c_TOT_CNT) && !r_overrun) begin
                    DATA_RX    <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                end else if ((r_write_en || r_read_en) && (r_bit_cnt != c_TOT_CNT)) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                if (w_sample) begin
                    if (r_bit_cnt < c_TOT_CNT) begin
                        r_bit_cnt <= r_bit_cnt + c_ONE;
                        if (r_bit_cnt < c_CMD_CNT) begin
                            r_cmd_sr <= w_cmd_new[CMD_W-1:1];
                        end else if (r_write_en) begin
                            r_rx_sr <= {w_mosi, r_rx_sr[DATA_W-1:1]};
                        end
                        if (r_bit_cnt == c_CMD_LAST) begin
                            CMD        <= w_cmd_new;
                            r_read_en  <= w_flags.read;
                            r_write_en <= w_flags.write;
                            if (w_flags.read) begin
                                r_tx_latch <= 1'b1;
                                r_tx_sr    <= DATA_TX;
                            end
                        end
                    end else begin
                        r_overrun <= 1'b1;
                        r_bit_cnt <= c_SAT_CNT;
                    end
                end
                if (w_shift) begin
                    if (r_out_cnt < c_CMD_CNT) begin
                        r_miso      <= r_status_sr[0];
                        r_status_sr <= {1'b0, r_status_sr[CMD_W-1:1]};
                        r_out_cnt   <= r_out_cnt + c_ONE;
                    end else begin
                        r_miso  <= r_tx_sr[0];
                        r_tx_sr <= {1'b0, r_tx_sr[DATA_W-1:1]};
                    end
                end
            end
        end
    end

    assign BUSY        = w_busy;
    assign SPI_MISO_OE = w_busy;
    assign SPI_MISO    = r_miso;
    assign RX_VALID    = r_rx_valid;
    assign TX_LATCH    = r_tx_latch;
    assign FRAME_ERR   = r_frame_err;

endmodule

`default_nettype wire

// File: doc/spi_slave_rpi_par.md
SPI_SLAVE_RPI_PAR -- requirements
Module: spi_slave_rpi_par

Interface
REQ-001 SHALL have parameter DATA_W, default 1024, payload bits per frame (8..4096).
REQ-002 SHALL have parameter CMD_W, default 8, command bits preceding payload (3..16).
REQ-003 SHALL have parameter CPOL, default 0, SPI clock idle level.
REQ-004 SHALL have parameter CPHA, default 0, SPI clock phase.
REQ-005 SHALL have parameter FILTER, default 5, input glitch-filter length in CLK cycles (0 = bypass).
REQ-006 SHALL have ports: CLK in 1 system clock; RESET in 1 synchronous active-high reset; one clock, synchronous active-high reset.
REQ-007 SHALL have ports: SPI_CS in 1 chip select (active low); SPI_CLK in 1; SPI_MOSI in 1; SPI_MISO out 1; SPI_MISO_OE out 1 MISO tri-state enable.
REQ-008 SHALL have ports: DATA_TX in DATA_W read payload; STATUS_TX in CMD_W status shifted during command phase; DATA_RX out DATA_W last complete written payload.
REQ-009 SHALL have ports: CMD out CMD_W last command; BUSY out 1 frame active; RX_VALID out 1 pulse; TX_LATCH out 1 pulse; FRAME_ERR out 1 pulse.

Function
REQ-010 SHALL pass SPI_CS/SPI_CLK/SPI_MOSI through a 2-FF synchroniser then a filter whose output changes only after input differs from output for FILTER consecutive samples.
REQ-011 SHALL start a frame on filtered CS falling edge: BUSY=1, bit counters=0, shift registers cleared.
REQ-012 SHALL sample MOSI on rising SPI_CLK when CPOL==CPHA, else falling; SHALL shift MISO on the opposite edge.
REQ-013 SHALL, when CPHA=0, drive first MISO bit one CLK after the CS falling edge is detected.
REQ-014 SHALL transfer LSB first: bits 0..CMD_W-1 are command, next DATA_W bits payload bit 0 upward.
REQ-015 SHALL decode command bit0 ENABLE, bit1 READ, bit2 WRITE; READ/WRITE effective only with ENABLE.
REQ-016 SHALL shift STATUS_TX (captured at frame start) on MISO during command phase.
REQ-017 SHALL latch DATA_TX and pulse TX_LATCH one CLK after the CMD_W-th sample edge when READ; payload MISO = latched bits, else 0.
REQ-018 SHALL store payload bits only when WRITE; CMD updates after the CMD_W-th sample.
REQ-019 SHALL saturate the bit counter at CMD_W+DATA_W+1; sample edges past CMD_W+DATA_W set overrun and are ignored.
REQ-020 SHALL on filtered CS rising edge: BUSY=0, MISO=0; if WRITE and exactly CMD_W+DATA_W bits and no overrun, update DATA_RX and pulse RX_VALID one CLK.
REQ-021 SHALL pulse FRAME_ERR instead if WRITE or READ was set and bit count != CMD_W+DATA_W; DATA_RX unchanged.
REQ-022 SHALL assert SPI_MISO_OE = BUSY.
REQ-023 SHALL ignore SPI_CLK edges while BUSY=0.
REQ-024 SHALL, on CS rise and CS fall in consecutive filtered cycles, finish the old frame first, then start the new one.

Reset
REQ-025 SHALL, while RESET=1, force SPI_MISO=0, SPI_MISO_OE=0, DATA_RX=0, CMD=0, BUSY=0, RX_VALID/TX_LATCH/FRAME_ERR=0, filters/synchronisers to idle (CS=1, SPI_CLK=CPOL, MOSI=0).
REQ-026 SHALL abort a frame in progress at reset without RX_VALID/FRAME_ERR; the next frame starts only on a fresh CS falling edge.

Structure
REQ-027 SHALL place command bit positions (ENABLE=0, READ=1, WRITE=2) and default parameter values in package spi_rpi_pkg.
REQ-028 SHALL instantiate sub-module spi_sync_filter (parameter FILTER) once per SPI input.

Verification
REQ-029 SHALL check DATA_W=32, mode 0, CMD=0x05, payload 0xDEADBEEF, full frame -> DATA_RX=0xDEADBEEF, RX_VALID one cycle after filtered CS rise.
REQ-030 SHALL check mode 3, CMD=0x03, DATA_TX=0x12345678, STATUS_TX=0xA5 -> MISO 0xA5 then 0x12345678 LSB first, TX_LATCH once.
REQ-031 SHALL check write frame with 20 payload bits then CS rise -> FRAME_ERR pulse, DATA_RX unchanged.
REQ-032 SHALL check 45 clocks in write frame (overrun) -> FRAME_ERR, DATA_RX unchanged, MISO=0 after bit 40.
REQ-033 SHALL check 2-cycle glitches on SPI_CLK with FILTER=5 -> no bit counted; RESET mid-frame -> all outputs reset values, no pulses.
